image_pipe_pack: RTL

Upstream feeder stage of the image pipe: accepts a stream of 8-bit pixels and packs four consecutive pixels into one 32-bit word on the image-pipe output interface. It honours the downstream busy handshake through a 3-entry output FIFO and flushes a zero-padded partial word at end of frame. A small CPU register port provides enable control and word/frame counters.

---
 rtl/image_pipe_pack_if.sv | 58 +++++
 rtl/image_pipe_pack.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/image_pipe_pack_if.sv
// image_pipe_pack bus bundle: pixel input, packed-word output
// with busy handshake, and the CPU register port.
interface image_pipe_pack_if;
  logic [7:0]  pix_data_in;
  logic        pix_valid_in;
  logic        pix_end_in;
  logic        pix_busy_out;
  logic [31:0] image_pipe_data_out;
  logic        image_pipe_valid_out;
  logic        image_pipe_end_out;
  logic        image_pipe_busy_in;
  logic        reg_cpu_cs;
  logic        reg_cpu_we;
  logic        reg_cpu_re;
  logic [31:2] reg_cpu_addr;
  logic [31:0] reg_cpu_data_wr;
  logic [31:0] reg_cpu_data_rd;
  logic        reg_cpu_wack;
  logic        reg_cpu_rdv;

  modport slave (
    input  pix_data_in,
    input  pix_valid_in,
    input  pix_end_in,
    output pix_busy_out,
    output image_pipe_data_out,
    output image_pipe_valid_out,
    output image_pipe_end_out,
    input  image_pipe_busy_in,
    input  reg_cpu_cs,
    input  reg_cpu_we,
    input  reg_cpu_re,
    input  reg_cpu_addr,
    input  reg_cpu_data_wr,
    output reg_cpu_data_rd,
    output reg_cpu_wack,
    output reg_cpu_rdv
  );

  modport master (
    output pix_data_in,
    output pix_valid_in,
    output pix_end_in,
    input  pix_busy_out,
    input  image_pipe_data_out,
    input  image_pipe_valid_out,
    input  image_pipe_end_out,
    output image_pipe_busy_in,
    output reg_cpu_cs,
    output reg_cpu_we,
    output reg_cpu_re,
    output reg_cpu_addr,
    output reg_cpu_data_wr,
    input  reg_cpu_data_rd,
    input  reg_cpu_wack,
    input  reg_cpu_rdv
  );
endinterface

// File: rtl/image_pipe_pack.sv
// Packs 8-bit pixels 4-per-word into a 3-deep output FIFO.
// Ports: clk, rst (sync, active high), io (slave side of bundle).
module image_pipe_pack (
  input  logic               clk,
  input  logic               rst,
  image_pipe_pack_if.slave   io
);

  localparam int DW_IN  = 8;
  localparam int DW_OUT = 32;

  logic [13:0] addr;
  assign addr = io.reg_cpu_addr[15:2];

  logic unused_bits;
  assign unused_bits = ^{io.reg_cpu_addr[31:16],
                         io.reg_cpu_data_wr[31:1]};

  logic              ctrl_en;
  logic [1:0]        lane;
  logic [23:0]       pack_q;
  logic [DW_OUT:0]   mem [3];
  logic [1:0]        rd_ptr;
  logic [1:0]        wr_ptr;
  logic [1:0]        cnt;
  logic [1:0]        cnt_nxt;
  logic [15:0]       words_q;
  logic [15:0]       frames_q;
  logic              busy_q;
  logic              re_q;
  logic              wack_q;
  logic              rdv_q;
  logic [31:0]       rd_q;
  logic [31:0]       rd_mux;
  logic [DW_OUT-1:0] word;

  logic accept;
  logic push;
  logic do_push;
  logic fifo_vld;
  logic pop;
  logic wr_ctrl;
  logic wr_stat;
  logic rd_edge;
  logic [DW_OUT:0] head;

  function automatic logic [1:0] ptr_inc(
    input logic [1:0] p
  );
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign accept   = io.pix_valid_in & ctrl_en;
  assign push     = accept &
                    ((lane == 2'd3) | io.pix_end_in);
  assign fifo_vld = (cnt != 2'd0);
  assign pop      = fifo_vld & ~io.image_pipe_busy_in;
  // A full FIFO only accepts when a pop frees a slot.
  assign do_push  = push & ((cnt != 2'd3) | pop);
  assign head     = mem[rd_ptr];

  assign wr_ctrl = io.reg_cpu_cs & io.reg_cpu_we &
                   (addr == 14'd0);
  assign wr_stat = io.reg_cpu_cs & io.reg_cpu_we &
                   (addr == 14'd1);
  assign rd_edge = io.reg_cpu_cs & io.reg_cpu_re & ~re_q;

  // Lanes above the current one are zero because
  // pack_q is cleared whenever a word leaves.
  always_comb begin
    word = {8'h00, pack_q};
    unique case (lane)
      2'd0: word[7:0]   = io.pix_data_in;
      2'd1: word[15:8]  = io.pix_data_in;
      2'd2: word[23:16] = io.pix_data_in;
      2'd3: word[31:24] = io.pix_data_in;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt;
    unique case ({do_push, pop})
      2'b10:   cnt_nxt = cnt + 2'd1;
      2'b01:   cnt_nxt = cnt - 2'd1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (addr == 14'd0): rd_mux = {31'd0, ctrl_en};
      (addr == 14'd1): rd_mux = {frames_q, words_q};
      default:         rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= {io.pix_end_in, word};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane   <= '0;
      pack_q <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else begin
      if (accept) begin
        if (push) begin
          lane   <= '0;
          pack_q <= '0;
        end else begin
          lane   <= lane + 2'd1;
          pack_q <= word[23:0];
        end
      end
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      cnt    <= cnt_nxt;
      busy_q <= (cnt_nxt >= 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_en  <= 1'b0;
      words_q  <= '0;
      frames_q <= '0;
      re_q     <= 1'b0;
      wack_q   <= 1'b0;
      rdv_q    <= 1'b0;
      rd_q     <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en <= io.reg_cpu_data_wr[0];
      end
      // A clear write beats a same-cycle pop.
      if (wr_stat) begin
        words_q  <= '0;
        frames_q <= '0;
      end else if (pop) begin
        words_q  <= words_q + 16'd1;
        frames_q <= frames_q + {15'd0, head[DW_OUT]};
      end
      re_q   <= io.reg_cpu_re;
      wack_q <= io.reg_cpu_cs & io.reg_cpu_we;
      rdv_q  <= io.reg_cpu_cs & io.reg_cpu_re;
      if (rd_edge) begin
        rd_q <= rd_mux;
      end
    end
  end

  assign io.image_pipe_valid_out = fifo_vld;
  assign io.image_pipe_data_out  =
    fifo_vld ? head[DW_OUT-1:0] : '0;
  assign io.image_pipe_end_out   =
    fifo_vld & head[DW_OUT];
  assign io.pix_busy_out         = busy_q;
  assign io.reg_cpu_wack         = wack_q;
  assign io.reg_cpu_rdv          = rdv_q;
  assign io.reg_cpu_data_rd      = rd_q;

  logic unused_dw;
  assign unused_dw = (DW_IN != 8);

endmodule
